// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: mux select encoding, stage record,
// and the producer-match helper used by every RAW check.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } stage_rec_t;

    // XZR is hardwired zero, so it never has a producer worth forwarding or stalling on.
    function automatic logic rec_hit(input stage_rec_t rec, input logic [4:0] src);
        return rec.valid && rec.reg_write && (rec.rd == src) && (src != XZR);
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One entry of the dependency shadow pipeline: holds a stage record, frozen on hold,
// cleared to an invalid record when a bubble is inserted.
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold_i,
    input  logic       bubble_i,
    input  stage_rec_t rec_i,
    output stage_rec_t rec_o
);

    stage_rec_t rec_q, rec_d;

    always_comb begin
        rec_d = rec_q;
        if (!hold_i) begin
            rec_d = bubble_i ? '0 : rec_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rec_o = rec_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// RAW hazard detection, load-use stall and EX operand forwarding selects.
// Define HAZARD_FWD_EN to enable forwarding; otherwise dependencies stall until WB.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold_i,
    input  logic             flush_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_ra_i,
    input  logic [4:0]       id_rb_i,
    input  logic             id_ra_used_i,
    input  logic             id_rb_used_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    output logic             stall_o,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic             ex_bubble_o,
    output logic [CNT_W-1:0] stall_count_o
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    stage_rec_t id_rec, ex_rec, mem_rec, wb_rec;
    logic       ra_ex, rb_ex, ra_mem, rb_mem;
    logic       hazard, stall_raw, insert_bubble;
    fwd_sel_e   sel_a, sel_b;

    fwd_sel_e         fwd_a_q, fwd_a_d;
    fwd_sel_e         fwd_b_q, fwd_b_d;
    logic             ex_bubble_q, ex_bubble_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign id_rec = '{valid:     id_valid_i,
                      rd:        id_rd_i,
                      reg_write: id_reg_write_i,
                      mem_read:  id_mem_read_i};

    assign ra_ex  = id_ra_used_i && rec_hit(ex_rec, id_ra_i);
    assign rb_ex  = id_rb_used_i && rec_hit(ex_rec, id_rb_i);
    assign ra_mem = id_ra_used_i && rec_hit(mem_rec, id_ra_i);
    assign rb_mem = id_rb_used_i && rec_hit(mem_rec, id_rb_i);

`ifdef HAZARD_FWD_EN
    assign hazard = (ra_ex || rb_ex) && ex_rec.mem_read;

    // Nearer producer wins; a load in EX never forwards because it forces a stall.
    always_comb begin
        sel_a = FWD_RF;
        sel_b = FWD_RF;
        if (ra_ex && !ex_rec.mem_read) begin
            sel_a = FWD_EXMEM;
        end else if (ra_mem) begin
            sel_a = FWD_MEMWB;
        end
        if (rb_ex && !ex_rec.mem_read) begin
            sel_b = FWD_EXMEM;
        end else if (rb_mem) begin
            sel_b = FWD_MEMWB;
        end
    end
`else
    // Without forwarding, wait until the producer reaches WB (regfile writes before read).
    assign hazard = ra_ex || rb_ex || ra_mem || rb_mem;
    assign sel_a  = FWD_RF;
    assign sel_b  = FWD_RF;
`endif

    assign stall_raw     = id_valid_i && hazard;
    assign stall_o       = stall_raw && !flush_i;
    assign insert_bubble = stall_raw || flush_i || !id_valid_i;

    hazard_stage_reg u_ex_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (hold_i),
        .bubble_i (insert_bubble),
        .rec_i    (id_rec),
        .rec_o    (ex_rec)
    );

    hazard_stage_reg u_mem_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (hold_i),
        .bubble_i (1'b0),
        .rec_i    (ex_rec),
        .rec_o    (mem_rec)
    );

    hazard_stage_reg u_wb_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (hold_i),
        .bubble_i (1'b0),
        .rec_i    (mem_rec),
        .rec_o    (wb_rec)
    );

    // WB is tracked to mirror the datapath but needs no check of its own.
    logic unused_wb;
    assign unused_wb = ^wb_rec;

    always_comb begin
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;
        ex_bubble_d = ex_bubble_q;
        cnt_d       = cnt_q;
        if (!hold_i) begin
            fwd_a_d     = insert_bubble ? FWD_RF : sel_a;
            fwd_b_d     = insert_bubble ? FWD_RF : sel_b;
            ex_bubble_d = insert_bubble;
            if (stall_o && (cnt_q != '1)) begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            ex_bubble_q <= 1'b1;
            cnt_q       <= '0;
        end else begin
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            ex_bubble_q <= ex_bubble_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fwd_a_sel_o   = fwd_a_q;
    assign fwd_b_sel_o   = fwd_b_q;
    assign ex_bubble_o   = ex_bubble_q;
    assign stall_count_o = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed, table-driven bench for hazard_fwd_ctrl; expectations follow HAZARD_FWD_EN.
module tb_hazard_fwd_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold, flush, id_valid;
    logic [4:0]    id_ra, id_rb, id_rd;
    logic          id_ra_used, id_rb_used, id_reg_write, id_mem_read;
    logic          stall;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          ex_bubble;
    logic [CW-1:0] stall_count;

    int total = 0;
    int bad   = 0;

    hazard_fwd_ctrl #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hold_i         (hold),
        .flush_i        (flush),
        .id_valid_i     (id_valid),
        .id_ra_i        (id_ra),
        .id_rb_i        (id_rb),
        .id_ra_used_i   (id_ra_used),
        .id_rb_used_i   (id_rb_used),
        .id_rd_i        (id_rd),
        .id_reg_write_i (id_reg_write),
        .id_mem_read_i  (id_mem_read),
        .stall_o        (stall),
        .fwd_a_sel_o    (fwd_a_sel),
        .fwd_b_sel_o    (fwd_b_sel),
        .ex_bubble_o    (ex_bubble),
        .stall_count_o  (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fl, v;
        logic [4:0] ra, rb;
        logic       rau, rbu;
        logic [4:0] rd;
        logic       rw, mr;
        logic       e_stall;
        logic [1:0] e_a, e_b;
        logic       e_bub;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

`ifdef HAZARD_FWD_EN
    localparam int LuStalls = 1;
    localparam int LuSelB   = 2;
`else
    localparam int LuStalls = 2;
    localparam int LuSelB   = 0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic v, input int ra, input int rb,
                       input logic rau, input logic rbu, input int rd, input logic rw,
                       input logic mr, input logic es, input int ea, input int eb,
                       input logic ebub, input int ecnt);
        vec_t r;
        r.fl = fl; r.v = v; r.ra = ra[4:0]; r.rb = rb[4:0]; r.rau = rau; r.rbu = rbu;
        r.rd = rd[4:0]; r.rw = rw; r.mr = mr; r.e_stall = es; r.e_a = ea[1:0];
        r.e_b = eb[1:0]; r.e_bub = ebub; r.e_cnt = ecnt;
        tbl.push_back(r);
    endtask

    task automatic nop(input int ecnt);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ecnt);
    endtask

    task automatic drive(input logic fl, input logic hd, input logic v, input int ra,
                         input int rb, input logic rau, input logic rbu, input int rd,
                         input logic rw, input logic mr);
        flush = fl; hold = hd; id_valid = v; id_ra = ra[4:0]; id_rb = rb[4:0];
        id_ra_used = rau; id_rb_used = rbu; id_rd = rd[4:0];
        id_reg_write = rw; id_mem_read = mr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1);
    end

    initial begin
        int c0;
        int exp_cnt;
        int nst;
        logic s;

        // fl v  ra rb au bu rd rw mr | stall a b bub cnt
`ifdef HAZARD_FWD_EN
        add(0, 1,  2, 3, 1, 1,  1, 1, 0,  0, 0, 0, 0, 0);
        add(0, 1,  1, 2, 1, 1,  3, 1, 0,  0, 1, 0, 0, 0);
        nop(0); nop(0);
        add(0, 1,  2, 3, 1, 1,  1, 1, 0,  0, 0, 0, 0, 0);
        nop(0);
        add(0, 1,  5, 1, 1, 1,  4, 1, 0,  0, 0, 2, 0, 0);
        nop(0); nop(0);
        add(0, 1, 10, 0, 1, 0,  2, 1, 1,  0, 0, 0, 0, 0);
        add(0, 1,  7, 2, 1, 1,  6, 1, 0,  1, 0, 0, 1, 1);
        add(0, 1,  7, 2, 1, 1,  6, 1, 0,  0, 0, 2, 0, 1);
        add(0, 1,  6, 6, 1, 1,  8, 1, 0,  0, 1, 1, 0, 1);
        add(0, 1,  8, 1, 1, 1,  8, 1, 0,  0, 1, 0, 0, 1);
        add(0, 1,  8, 6, 1, 1, 10, 1, 0,  0, 1, 0, 0, 1);
        add(0, 1, 10, 8, 0, 1, 11, 1, 0,  0, 0, 2, 0, 1);
        nop(1); nop(1);
        add(0, 1,  2, 3, 1, 1, 31, 1, 0,  0, 0, 0, 0, 1);
        add(0, 1, 31,31, 1, 1,  5, 1, 0,  0, 0, 0, 0, 1);
        add(0, 1, 10, 0, 1, 0, 31, 1, 1,  0, 0, 0, 0, 1);
        add(0, 1, 31, 5, 1, 1,  4, 1, 0,  0, 0, 2, 0, 1);
        nop(1); nop(1);
        add(0, 1, 10, 0, 1, 0,  2, 1, 1,  0, 0, 0, 0, 1);
        add(1, 1,  7, 2, 1, 1,  6, 1, 0,  0, 0, 0, 1, 1);
        add(1, 1,  1, 2, 1, 1,  3, 1, 0,  0, 0, 0, 1, 1);
        add(0, 1, 10, 0, 1, 0,  2, 1, 1,  0, 0, 0, 0, 1);
        add(0, 0,  2, 2, 1, 1,  6, 1, 0,  0, 0, 0, 1, 1);
        nop(1);
`else
        add(0, 1,  2, 3, 1, 1,  1, 1, 0,  0, 0, 0, 0, 0);
        add(0, 1,  1, 2, 1, 1,  3, 1, 0,  1, 0, 0, 1, 1);
        add(0, 1,  1, 2, 1, 1,  3, 1, 0,  1, 0, 0, 1, 2);
        add(0, 1,  1, 2, 1, 1,  3, 1, 0,  0, 0, 0, 0, 2);
        nop(2); nop(2);
        add(0, 1,  2, 3, 1, 1,  1, 1, 0,  0, 0, 0, 0, 2);
        nop(2);
        add(0, 1,  5, 1, 1, 1,  4, 1, 0,  1, 0, 0, 1, 3);
        add(0, 1,  5, 1, 1, 1,  4, 1, 0,  0, 0, 0, 0, 3);
        nop(3); nop(3);
        add(0, 1, 10, 0, 1, 0,  2, 1, 1,  0, 0, 0, 0, 3);
        add(0, 1,  7, 2, 1, 1,  6, 1, 0,  1, 0, 0, 1, 4);
        add(0, 1,  7, 2, 1, 1,  6, 1, 0,  1, 0, 0, 1, 5);
        add(0, 1,  7, 2, 1, 1,  6, 1, 0,  0, 0, 0, 0, 5);
        add(0, 1,  6, 1, 0, 1,  9, 1, 0,  0, 0, 0, 0, 5);
        nop(5); nop(5);
        add(0, 1,  2, 3, 1, 1, 31, 1, 0,  0, 0, 0, 0, 5);
        add(0, 1, 31,31, 1, 1,  5, 1, 0,  0, 0, 0, 0, 5);
        nop(5); nop(5);
        add(0, 1, 10, 0, 1, 0,  2, 1, 1,  0, 0, 0, 0, 5);
        add(1, 1,  7, 2, 1, 1,  6, 1, 0,  0, 0, 0, 1, 5);
        add(1, 1,  1, 2, 1, 1,  3, 1, 0,  0, 0, 0, 1, 5);
        add(0, 1, 10, 0, 1, 0,  2, 1, 1,  0, 0, 0, 0, 5);
        add(0, 0,  2, 2, 1, 1,  6, 1, 0,  0, 0, 0, 1, 5);
        nop(5);
`endif

        // Reset state, with a would-be hazard on the ID inputs.
        rst_n = 1'b0;
        drive(0, 0, 1, 2, 2, 1, 1, 6, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", int'(stall), 0);
        chk("reset fwd_a", int'(fwd_a_sel), 0);
        chk("reset fwd_b", int'(fwd_b_sel), 0);
        chk("reset bubble", int'(ex_bubble), 1);
        chk("reset count", int'(stall_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].fl, 0, tbl[i].v, int'(tbl[i].ra), int'(tbl[i].rb), tbl[i].rau,
                  tbl[i].rbu, int'(tbl[i].rd), tbl[i].rw, tbl[i].mr);
            #2;
            chk($sformatf("row%0d stall", i), int'(stall), int'(tbl[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d fwd_a", i), int'(fwd_a_sel), int'(tbl[i].e_a));
            chk($sformatf("row%0d fwd_b", i), int'(fwd_b_sel), int'(tbl[i].e_b));
            chk($sformatf("row%0d bubble", i), int'(ex_bubble), int'(tbl[i].e_bub));
            chk($sformatf("row%0d count", i), int'(stall_count), tbl[i].e_cnt);
        end
        c0 = tbl[tbl.size()-1].e_cnt;

        // Load-use frozen by hold for 3 cycles, then async reset while still held.
        drive(0, 0, 1, 10, 0, 1, 0, 2, 1, 1);
        @(posedge clk);
        #1;
        chk("hold ld bubble", int'(ex_bubble), 0);
        drive(0, 1, 1, 7, 2, 1, 1, 6, 1, 0);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("hold%0d stall", k), int'(stall), 1);
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d fwd_b", k), int'(fwd_b_sel), 0);
            chk($sformatf("hold%0d bubble", k), int'(ex_bubble), 0);
            chk($sformatf("hold%0d count", k), int'(stall_count), c0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst fwd_a", int'(fwd_a_sel), 0);
        chk("async rst fwd_b", int'(fwd_b_sel), 0);
        chk("async rst bubble", int'(ex_bubble), 1);
        chk("async rst count", int'(stall_count), 0);
        chk("async rst stall", int'(stall), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Repeated load-use pairs drive the counter into saturation.
        exp_cnt = 0;
        for (int it = 0; it < 20; it++) begin
            drive(0, 0, 1, 10, 0, 1, 0, 2, 1, 1);
            @(posedge clk);
            #1;
            drive(0, 0, 1, 7, 2, 1, 1, 6, 1, 0);
            nst = 0;
            for (int k = 0; k < 6; k++) begin
                #2;
                s = stall;
                if (s) begin
                    nst++;
                    if (exp_cnt < 15) exp_cnt++;
                end
                @(posedge clk);
                #1;
                if (!s) break;
            end
            chk($sformatf("sat%0d stalls", it), nst, LuStalls);
            chk($sformatf("sat%0d count", it), int'(stall_count), exp_cnt);
            chk($sformatf("sat%0d fwd_b", it), int'(fwd_b_sel), LuSelB);
            chk($sformatf("sat%0d bubble", it), int'(ex_bubble), 0);
        end
        chk("saturated count", int'(stall_count), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
